decode: RTL and testbench

- Instruction decoder for the RV32I subset used by the OOO core front end.
- Splits a 32-bit instruction into architectural register addresses and a sign-extended 32-bit immediate.
- Produces the control bundle (ALU source/op, branch/jump, memory, writeback) consumed by rename/dispatch.
- Combinational by default; an optional output register stage exists for timing closure.

---
 rtl/decode.sv | 155 +++++++++++++++
 tb/tb_decode.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// RV32I subset decoder: register fields, sign-extended immediate and control bundle.
// Latency 0 (REG_OUT=0) or 1 cycle (REG_OUT=1); no backpressure, accepts a word every cycle.
module decode #(
    parameter int REG_OUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_in,
    output logic [4:0]  rs1_addr_out,
    output logic [4:0]  rs2_addr_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] immediate_out,
    output logic        ALUSrc_out,
    output logic [2:0]  ALUOp_out,
    output logic        Branch_en_out,
    output logic        Jump_en_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out
);

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic        branch;
        logic        jump;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } ctrl_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam ctrl_t NOP_BUNDLE = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
                                     alu_src: 1'b0, alu_op: 3'b111, branch: 1'b0,
                                     jump: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                     reg_write: 1'b0, mem_to_reg: 1'b0};

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    ctrl_t       dec_d;
    ctrl_t       dec_out;

    assign imm_i = {{20{instruction_in[31]}}, instruction_in[31:20]};
    assign imm_s = {{20{instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
    assign imm_b = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                    instruction_in[30:25], instruction_in[11:8], 1'b0};
    assign imm_u = {instruction_in[31:12], 12'd0};

    always_comb begin
        dec_d = NOP_BUNDLE;
        case (instruction_in[6:0])
            OP_R: begin
                dec_d.rs1       = instruction_in[19:15];
                dec_d.rs2       = instruction_in[24:20];
                dec_d.rd        = instruction_in[11:7];
                dec_d.alu_op    = 3'b001;
                dec_d.reg_write = 1'b1;
            end
            OP_IALU: begin
                dec_d.rs1       = instruction_in[19:15];
                dec_d.rd        = instruction_in[11:7];
                dec_d.imm       = imm_i;
                dec_d.alu_src   = 1'b1;
                dec_d.alu_op    = 3'b010;
                dec_d.reg_write = 1'b1;
            end
            OP_LOAD: begin
                dec_d.rs1        = instruction_in[19:15];
                dec_d.rd         = instruction_in[11:7];
                dec_d.imm        = imm_i;
                dec_d.alu_src    = 1'b1;
                dec_d.alu_op     = 3'b000;
                dec_d.mem_read   = 1'b1;
                dec_d.reg_write  = 1'b1;
                dec_d.mem_to_reg = 1'b1;
            end
            OP_ST: begin
                dec_d.rs1       = instruction_in[19:15];
                dec_d.rs2       = instruction_in[24:20];
                dec_d.imm       = imm_s;
                dec_d.alu_src   = 1'b1;
                dec_d.alu_op    = 3'b000;
                dec_d.mem_write = 1'b1;
            end
            OP_BR: begin
                dec_d.rs1    = instruction_in[19:15];
                dec_d.rs2    = instruction_in[24:20];
                dec_d.imm    = imm_b;
                dec_d.alu_op = 3'b011;
                dec_d.branch = 1'b1;
            end
            OP_JALR: begin
                dec_d.rs1       = instruction_in[19:15];
                dec_d.rd        = instruction_in[11:7];
                dec_d.imm       = imm_i;
                dec_d.alu_src   = 1'b1;
                dec_d.alu_op    = 3'b101;
                dec_d.jump      = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OP_LUI: begin
                dec_d.rd        = instruction_in[11:7];
                dec_d.imm       = imm_u;
                dec_d.alu_op    = 3'b100;
                dec_d.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            ctrl_t dec_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) dec_q <= NOP_BUNDLE;
                else       dec_q <= dec_d;
            end
            assign dec_out = dec_q;
        end else begin : g_comb
            // clk/reset are intentionally unused in the combinational build
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dec_out = dec_d;
        end
    endgenerate

    assign rs1_addr_out  = dec_out.rs1;
    assign rs2_addr_out  = dec_out.rs2;
    assign rd_addr_out   = dec_out.rd;
    assign immediate_out = dec_out.imm;
    assign ALUSrc_out    = dec_out.alu_src;
    assign ALUOp_out     = dec_out.alu_op;
    assign Branch_en_out = dec_out.branch;
    assign Jump_en_out   = dec_out.jump;
    assign MemRead_out   = dec_out.mem_read;
    assign MemWrite_out  = dec_out.mem_write;
    assign RegWrite_out  = dec_out.reg_write;
    assign MemToReg_out  = dec_out.mem_to_reg;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: combinational and registered instances, vector table, random model checks.
module tb_decode;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic        branch;
        logic        jump;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_c = 32'd0;
    logic [31:0] instr_r = 32'd0;
    int          checks = 0;
    int          errors = 0;

    logic [4:0]  rs1_c, rs2_c, rd_c, rs1_r, rs2_r, rd_r;
    logic [31:0] imm_c, imm_r;
    logic [2:0]  op_c, op_r;
    logic        src_c, br_c, jmp_c, mr_c, mw_c, rw_c, m2r_c;
    logic        src_r, br_r, jmp_r, mr_r, mw_r, rw_r, m2r_r;
    exp_t        got_c, got_r;

    always #5 clk = ~clk;

    decode #(.REG_OUT(0)) u_comb (
        .clk(clk), .reset(rst), .instruction_in(instr_c),
        .rs1_addr_out(rs1_c), .rs2_addr_out(rs2_c), .rd_addr_out(rd_c),
        .immediate_out(imm_c), .ALUSrc_out(src_c), .ALUOp_out(op_c),
        .Branch_en_out(br_c), .Jump_en_out(jmp_c), .MemRead_out(mr_c),
        .MemWrite_out(mw_c), .RegWrite_out(rw_c), .MemToReg_out(m2r_c)
    );

    decode #(.REG_OUT(1)) u_reg (
        .clk(clk), .reset(rst), .instruction_in(instr_r),
        .rs1_addr_out(rs1_r), .rs2_addr_out(rs2_r), .rd_addr_out(rd_r),
        .immediate_out(imm_r), .ALUSrc_out(src_r), .ALUOp_out(op_r),
        .Branch_en_out(br_r), .Jump_en_out(jmp_r), .MemRead_out(mr_r),
        .MemWrite_out(mw_r), .RegWrite_out(rw_r), .MemToReg_out(m2r_r)
    );

    assign got_c = {rs1_c, rs2_c, rd_c, imm_c, src_c, op_c, br_c, jmp_c, mr_c, mw_c, rw_c, m2r_c};
    assign got_r = {rs1_r, rs2_r, rd_r, imm_r, src_r, op_r, br_r, jmp_r, mr_r, mw_r, rw_r, m2r_r};

    // flags order: branch, jump, mem_read, mem_write, reg_write, mem_to_reg
    function automatic exp_t mk(input int r1, input int r2, input int d, input logic [31:0] imm,
                                input bit src, input int op, input logic [5:0] flags);
        exp_t e;
        e.rs1 = 5'(r1);
        e.rs2 = 5'(r2);
        e.rd  = 5'(d);
        e.imm = imm;
        e.alu_src = src;
        e.alu_op  = 3'(op);
        {e.branch, e.jump, e.mem_read, e.mem_write, e.reg_write, e.mem_to_reg} = flags;
        return e;
    endfunction

    // Reference: immediates built by arithmetic scaling of instruction fields.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t              e;
        bit                u1, u2, ud;
        logic signed [31:0] hi;
        logic [31:0]       imm;
        e = mk(0, 0, 0, 32'd0, 0, 7, 6'b0);
        u1 = 0; u2 = 0; ud = 0; imm = 32'd0;
        case (ins[6:0])
            7'h33: begin u1 = 1; u2 = 1; ud = 1; e.alu_op = 3'd1; e.reg_write = 1; end
            7'h13: begin
                u1 = 1; ud = 1; hi = $signed(ins) >>> 20; imm = hi;
                e.alu_src = 1; e.alu_op = 3'd2; e.reg_write = 1;
            end
            7'h03: begin
                u1 = 1; ud = 1; hi = $signed(ins) >>> 20; imm = hi;
                e.alu_src = 1; e.alu_op = 3'd0; e.mem_read = 1; e.reg_write = 1; e.mem_to_reg = 1;
            end
            7'h23: begin
                u1 = 1; u2 = 1; hi = $signed(ins) >>> 25; imm = hi * 32 + ins[11:7];
                e.alu_src = 1; e.alu_op = 3'd0; e.mem_write = 1;
            end
            7'h63: begin
                u1 = 1; u2 = 1; hi = $signed(ins) >>> 31;
                imm = hi * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
                e.alu_op = 3'd3; e.branch = 1;
            end
            7'h67: begin
                u1 = 1; ud = 1; hi = $signed(ins) >>> 20; imm = hi;
                e.alu_src = 1; e.alu_op = 3'd5; e.jump = 1; e.reg_write = 1;
            end
            7'h37: begin
                ud = 1; imm = ins & 32'hFFFF_F000; e.alu_op = 3'd4; e.reg_write = 1;
            end
            default: ;
        endcase
        e.rs1 = u1 ? ins[19:15] : 5'd0;
        e.rs2 = u2 ? ins[24:20] : 5'd0;
        e.rd  = ud ? ins[11:7]  : 5'd0;
        e.imm = imm;
        return e;
    endfunction

    task automatic chk(input string nm, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37};
        logic [31:0] ins;
        int          pick;
        ins  = $urandom;
        pick = $urandom_range(0, 9);
        if (pick < 7) ins[6:0] = ops[pick];
        return ins;
    endfunction

    initial begin
        vec_t        vecs[$];
        exp_t        nop;
        exp_t        addi_e;
        logic [31:0] prev;
        logic [31:0] ins;

        nop    = mk(0, 0, 0, 32'd0, 0, 7, 6'b000000);
        addi_e = mk(0, 0, 5, 32'd154, 1, 2, 6'b000010);
        vecs.push_back('{"nop_zero", 32'h0000_0000, nop});
        vecs.push_back('{"nop_jal",  32'h0000_006F, nop});
        vecs.push_back('{"nop_auipc", 32'h0000_0017, nop});
        vecs.push_back('{"nop_system", 32'h0000_0073, nop});
        vecs.push_back('{"addi",  32'h09A0_0293, addi_e});
        vecs.push_back('{"addi_neg", 32'hBAD0_0193, mk(0, 0, 3, 32'hFFFF_FBAD, 1, 2, 6'b000010)});
        vecs.push_back('{"lui",   32'h0BEE_F137, mk(0, 0, 2, 32'h0BEE_F000, 0, 4, 6'b000010)});
        vecs.push_back('{"sra",   32'h4053_53B3, mk(6, 5, 7, 32'd0, 0, 1, 6'b000010)});
        vecs.push_back('{"sub",   32'h4063_8433, mk(7, 6, 8, 32'd0, 0, 1, 6'b000010)});
        vecs.push_back('{"and",   32'h0074_74B3, mk(8, 7, 9, 32'd0, 0, 1, 6'b000010)});
        vecs.push_back('{"lw",    32'h0200_A583, mk(1, 0, 11, 32'd32, 1, 0, 6'b001011)});
        vecs.push_back('{"sh",    32'h0053_1423, mk(6, 5, 0, 32'd8, 1, 0, 6'b000100)});
        vecs.push_back('{"sw_neg", 32'hFE11_2E23, mk(2, 1, 0, 32'hFFFF_FFFC, 1, 0, 6'b000100)});
        vecs.push_back('{"bne",   32'hFE00_9CE3, mk(1, 0, 0, 32'hFFFF_FFF8, 0, 3, 6'b100000)});
        vecs.push_back('{"jalr",  32'h07B0_00E7, mk(0, 0, 1, 32'd123, 1, 5, 6'b010010)});

        #1 rst = 1'b1;
        #1 chk("reg_reset_async", got_r, nop);

        foreach (vecs[i]) begin
            instr_c = vecs[i].ins;
            #1 chk(vecs[i].name, got_c, vecs[i].exp);
        end

        for (int i = 0; i < 300; i++) begin
            instr_c = rand_ins();
            #1 chk("rand_comb", got_c, model(instr_c));
        end

        // Registered instance: reset hold, release, async reassert mid-cycle.
        repeat (2) @(negedge clk);
        chk("reg_reset_held", got_r, nop);
        instr_r = 32'h09A0_0293;
        @(negedge clk);
        chk("reg_hold_nop_in_reset", got_r, nop);
        rst = 1'b0;
        #1 chk("reg_nop_before_edge", got_r, nop);
        @(negedge clk);
        chk("reg_addi_after_edge", got_r, addi_e);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("reg_async_reset_midcycle", got_r, nop);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reg_nop_after_release", got_r, nop);
        @(negedge clk);
        chk("reg_addi_one_edge_later", got_r, addi_e);

        prev = instr_r;
        for (int i = 0; i < 200; i++) begin
            ins = rand_ins();
            instr_r = ins;
            #1 chk("reg_latency_hold", got_r, model(prev));
            @(negedge clk);
            chk("rand_reg", got_r, model(ins));
            prev = ins;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
